// File: rtl/ahb_apb_ctrl.sv
// AHB-to-APB bridge: decodes AHB transfers into three APB slave selects and
// sequences each one as a single setup cycle followed by a single access cycle.
//
// state        | meaning
// ST_IDLE      | no transfer pending, bus ready
// ST_WWAIT     | write address taken, waiting for its data phase
// ST_READ      | APB read setup cycle
// ST_WRITE     | APB write setup, nothing queued behind it
// ST_WRITEP    | APB write setup, another transfer already accepted
// ST_RENABLE   | APB read access cycle
// ST_WENABLE   | APB write access cycle, nothing queued
// ST_WENABLEP  | APB write access cycle, queued transfer waiting in the pipeline
module ahb_apb_ctrl (
    input  logic        clock,
    input  logic        Hresetn,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    input  logic [31:0] Prdata,
    output logic        Hreadyout,
    output logic [31:0] Hrdata,
    output logic [1:0]  Hresp,
    output logic [2:0]  Pselx,
    output logic [31:0] Paddr,
    output logic [31:0] Pwdata,
    output logic        Pwrite,
    output logic        Penable
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_READ,
        ST_WRITE,
        ST_WRITEP,
        ST_RENABLE,
        ST_WENABLE,
        ST_WENABLEP
    } state_t;

    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic        Hwrite_reg;
    logic [2:0]  sel;
    logic        valid;

    // Each slave owns a 64 MB window starting at 0x8000_0000.
    function automatic logic [2:0] decode(input logic [31:0] addr);
        logic [2:0] s;
        case (addr[31:26])
            6'b100000: s = 3'b001;
            6'b100001: s = 3'b010;
            6'b100010: s = 3'b100;
            default:   s = 3'b000;
        endcase
        return s;
    endfunction

    assign sel    = decode(Haddr);
    assign valid  = Hreadyin && ((Htrans == TR_NONSEQ) || (Htrans == TR_SEQ)) && (sel != 3'b000);
    assign Hrdata = Prdata;
    assign Hresp  = 2'b00;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (valid && Hwrite)
                    state_nxt = ST_WWAIT;
                else if (valid)
                    state_nxt = ST_READ;
                else
                    state_nxt = ST_IDLE;
            end
            ST_WWAIT:    state_nxt = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     state_nxt = ST_RENABLE;
            ST_WRITEP:   state_nxt = ST_WENABLEP;
            ST_WRITE:    state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WENABLEP: begin
                if (!Hwrite_reg)
                    state_nxt = ST_READ;
                else if (valid)
                    state_nxt = ST_WRITEP;
                else
                    state_nxt = ST_WRITE;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= ST_IDLE;
            Haddr1     <= '0;
            Haddr2     <= '0;
            Hwdata1    <= '0;
            Hwrite_reg <= 1'b0;
            Pselx      <= 3'b000;
            Paddr      <= '0;
            Pwdata     <= '0;
            Pwrite     <= 1'b0;
            Penable    <= 1'b0;
            Hreadyout  <= 1'b1;
        end else begin
            state      <= state_nxt;
            Haddr1     <= Haddr;
            Haddr2     <= Haddr1;
            Hwdata1    <= Hwdata;
            Hwrite_reg <= Hwrite;
            case (state_nxt)
                ST_READ: begin
                    Paddr     <= Haddr;
                    Pselx     <= sel;
                    Pwrite    <= 1'b0;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    // A queued write has slipped one stage further down the pipeline.
                    if (state == ST_WENABLEP) begin
                        Paddr  <= Haddr2;
                        Pselx  <= decode(Haddr2);
                        Pwdata <= Hwdata1;
                    end else begin
                        Paddr  <= Haddr1;
                        Pselx  <= decode(Haddr1);
                        Pwdata <= Hwdata;
                    end
                    Pwrite    <= 1'b1;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b0;
                end
                ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                    Penable   <= 1'b1;
                    Hreadyout <= 1'b1;
                end
                default: begin
                    Pselx     <= 3'b000;
                    Penable   <= 1'b0;
                    Hreadyout <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// Bench for ahb_apb_ctrl: a small AHB master drives directed sequences and an
// APB monitor pops expected transfers from a scoreboard queue on each access cycle.
module tb_ahb_apb_ctrl;

    logic        clock = 1'b0;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic [31:0] Prdata;
    logic        Hreadyout;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;
    logic [2:0]  Pselx;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic        Pwrite;
    logic        Penable;

    ahb_apb_ctrl dut (
        .clock     (clock),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .Prdata    (Prdata),
        .Hreadyout (Hreadyout),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp),
        .Pselx     (Pselx),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Pwrite    (Pwrite),
        .Penable   (Penable)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [1:0]  trans;
    } xfer_t;

    exp_t  exp_q[$];
    xfer_t seq_q[$];

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int n_access  = 0;
    bit ign_mode    = 1'b0;
    bit nready_mode = 1'b0;

    logic        prev_pen   = 1'b0;
    logic [31:0] prev_paddr = '0;
    logic [2:0]  prev_psel  = '0;
    logic        prev_pwr   = 1'b0;
    exp_t        mon_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] model_sel(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    task automatic add_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] data,
                            input logic [1:0] trans);
        seq_q.push_back('{addr: addr, wr: wr, data: data, trans: trans});
        if (!nready_mode && trans[1] && model_sel(addr) != 3'b000)
            exp_q.push_back('{sel: model_sel(addr), addr: addr, wr: wr, data: data});
    endtask

    task automatic drive_addr(input xfer_t x);
        Htrans = x.trans;
        Haddr  = x.addr;
        Hwrite = x.wr;
    endtask

    // Minimal AHB master: advances when the previous edge saw Hreadyin high,
    // and parks on IDLE keeping the last address and direction.
    task automatic run_seq(input int max_cycles);
        int   idx   = 0;
        int   drain = 0;
        int   cyc   = 0;
        int   n     = seq_q.size();
        logic rdy;
        @(negedge clock);
        drive_addr(seq_q[0]);
        Hreadyin = nready_mode ? 1'b0 : Hreadyout;
        while (drain < 6 && cyc < max_cycles) begin
            @(posedge clock);
            rdy = Hreadyin;
            @(negedge clock);
            cyc++;
            if (rdy && idx < n) begin
                if (seq_q[idx].wr) Hwdata = seq_q[idx].data;
                idx++;
                if (idx < n) drive_addr(seq_q[idx]);
                else Htrans = 2'b00;
            end
            if (idx == n) drain++;
            if (ign_mode) check("ignored_pselx", 32'(Pselx), 32'd0);
            Hreadyin = nready_mode ? 1'b0 : Hreadyout;
        end
        if (!nready_mode) check("master_done", idx, n);
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        seq_q.delete();
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_exp_empty"}, exp_q.size(), 0);
        check({tag, "_idle_psel"}, 32'(Pselx), 32'd0);
        check({tag, "_idle_pen"}, 32'(Penable), 32'd0);
        check({tag, "_idle_ready"}, 32'(Hreadyout), 32'd1);
    endtask

    // APB monitor / scoreboard consumer
    always @(negedge clock) begin
        if (Hresetn) begin
            if (Penable) begin
                n_access++;
                check("pen_sel_nonzero", 32'(Pselx != 3'b000), 32'd1);
                check("setup_before_access", 32'(prev_pen), 32'd0);
                check("setup_addr_held", prev_paddr, Paddr);
                check("setup_sel_held", 32'(prev_psel), 32'(Pselx));
                check("setup_dir_held", 32'(prev_pwr), 32'(Pwrite));
                check("access_ready", 32'(Hreadyout), 32'd1);
                check("exp_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("acc_sel", 32'(Pselx), 32'(mon_e.sel));
                    check("acc_addr", Paddr, mon_e.addr);
                    check("acc_write", 32'(Pwrite), 32'(mon_e.wr));
                    if (mon_e.wr) check("acc_wdata", Pwdata, mon_e.data);
                    else          check("acc_rdata", Hrdata, mon_e.data);
                end
            end
            if (!Hreadyout)
                check("ready_low_only_setup", 32'(Pselx != 3'b000 && !Penable), 32'd1);
            check("hresp_okay", 32'(Hresp), 32'd0);
        end
        prev_pen   = Penable;
        prev_paddr = Paddr;
        prev_psel  = Pselx;
        prev_pwr   = Pwrite;
    end

    int acc_before;

    initial begin
        Hresetn  = 1'b0;
        Hwrite   = 1'b0;
        Hreadyin = 1'b1;
        Htrans   = 2'b00;
        Haddr    = '0;
        Hwdata   = '0;
        Prdata   = '0;
        repeat (2) @(negedge clock);
        check("rst_pselx", 32'(Pselx), 32'd0);
        check("rst_penable", 32'(Penable), 32'd0);
        check("rst_pwrite", 32'(Pwrite), 32'd0);
        check("rst_paddr", Paddr, 32'd0);
        check("rst_pwdata", Pwdata, 32'd0);
        check("rst_hready", 32'(Hreadyout), 32'd1);
        check("rst_hresp", 32'(Hresp), 32'd0);
        Hresetn = 1'b1;

        // single read
        Prdata = 32'hA5A5_0001;
        add_xfer(32'h8000_0010, 1'b0, 32'hA5A5_0001, 2'b10);
        run_seq(40);
        end_checks("read1");

        // single write
        add_xfer(32'h8400_0004, 1'b1, 32'h1234_5678, 2'b10);
        run_seq(40);
        end_checks("write1");

        // INCR4 write burst
        for (int i = 0; i < 4; i++)
            add_xfer(32'h8800_0000 + 32'(4 * i), 1'b1, 32'hDA7A_0000 + 32'(i),
                     (i == 0) ? 2'b10 : 2'b11);
        run_seq(60);
        end_checks("burst");

        // back-to-back reads at map boundaries
        Prdata = 32'h5A5A_F00D;
        add_xfer(32'h83FF_FFFC, 1'b0, 32'h5A5A_F00D, 2'b10);
        add_xfer(32'h8400_0000, 1'b0, 32'h5A5A_F00D, 2'b10);
        add_xfer(32'h8BFF_FFFC, 1'b0, 32'h5A5A_F00D, 2'b10);
        add_xfer(32'h8800_0000, 1'b0, 32'h5A5A_F00D, 2'b10);
        run_seq(60);
        end_checks("bound_rd");

        // ignored transfers
        acc_before = n_access;
        ign_mode = 1'b1;
        add_xfer(32'h8000_0000, 1'b1, 32'h1111_1111, 2'b00);
        add_xfer(32'h8000_0004, 1'b1, 32'h2222_2222, 2'b01);
        add_xfer(32'h9000_0000, 1'b1, 32'h3333_3333, 2'b10);
        add_xfer(32'h8C00_0000, 1'b0, 32'h0, 2'b10);
        add_xfer(32'h7FFF_FFFC, 1'b0, 32'h0, 2'b10);
        run_seq(40);
        check("ignored_no_access", n_access - acc_before, 0);
        nready_mode = 1'b1;
        add_xfer(32'h8000_0000, 1'b0, 32'h0, 2'b10);
        run_seq(8);
        check("nready_no_access", n_access - acc_before, 0);
        nready_mode = 1'b0;
        ign_mode    = 1'b0;
        end_checks("ignored");

        // write followed directly by read
        Prdata = 32'hCAFE_0042;
        add_xfer(32'h8000_0100, 1'b1, 32'h0BAD_F00D, 2'b10);
        add_xfer(32'h8400_0200, 1'b0, 32'hCAFE_0042, 2'b10);
        run_seq(40);
        end_checks("wr_rd");

        // read, write, read
        Prdata = 32'h0F0F_1234;
        add_xfer(32'h8800_0040, 1'b0, 32'h0F0F_1234, 2'b10);
        add_xfer(32'h8000_0044, 1'b1, 32'h1357_9BDF, 2'b10);
        add_xfer(32'h8400_0048, 1'b0, 32'h0F0F_1234, 2'b10);
        run_seq(60);
        end_checks("rd_wr_rd");

        // reset asserted during a write access cycle
        @(negedge clock);
        Htrans   = 2'b10;
        Hwrite   = 1'b1;
        Haddr    = 32'h8400_0008;
        Hreadyin = 1'b1;
        exp_q.push_back('{sel: 3'b010, addr: 32'h8400_0008, wr: 1'b1, data: 32'hFEED_0001});
        @(negedge clock);
        Hwdata = 32'hFEED_0001;
        Htrans = 2'b00;
        @(negedge clock);
        check("rstw_setup_pen", 32'(Penable), 32'd0);
        check("rstw_setup_pwrite", 32'(Pwrite), 32'd1);
        @(negedge clock);
        check("rstw_access_pen", 32'(Penable), 32'd1);
        #2 Hresetn = 1'b0;
        #1;
        check("rstw_pselx", 32'(Pselx), 32'd0);
        check("rstw_penable", 32'(Penable), 32'd0);
        check("rstw_pwrite", 32'(Pwrite), 32'd0);
        check("rstw_paddr", Paddr, 32'd0);
        check("rstw_pwdata", Pwdata, 32'd0);
        check("rstw_hready", 32'(Hreadyout), 32'd1);
        @(negedge clock);
        check("rstw_hold_pen", 32'(Penable), 32'd0);
        Hresetn = 1'b1;
        @(negedge clock);
        check("rstw_no_completion", 32'(Penable), 32'd0);
        check("rstw_no_psel", 32'(Pselx), 32'd0);
        end_checks("rstw");

        // clean read after reset
        Prdata = 32'h7777_0020;
        add_xfer(32'h8000_0020, 1'b0, 32'h7777_0020, 2'b10);
        run_seq(40);
        end_checks("post_rst_rd");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
